stream_demux: RTL and testbench

- Parametrised registered 1:N demultiplexer for valid/ready streams; successor to the combinational 4-way demux.
- Routes each accepted input word, selected by in_sel, to one of CHANNELS output channels.
- Each channel has a one-entry output register, so a stalled channel does not block traffic to the others.
- Gated by a global enable; sits between a single producer and N independent consumers.

---
 rtl/stream_pkg.sv | 16 +
 rtl/stream_demux_if.sv | 36 +++
 rtl/stream_demux_slot.sv | 50 +++++
 rtl/stream_demux.sv | 94 +++++++++
 tb/tb_stream_demux.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream demultiplexer slice.
//   sel_width(n) : select width for an n-way choice, never below 1 bit.
//   STAT_W       : width of each per-channel transfer counter.
//   STAT_MAX     : saturation value of those counters.
package stream_pkg;

  localparam int unsigned STAT_W   = 16;
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Valid/ready bundle between one producer, the demux and CHANNELS consumers.
//   in_valid/in_ready/in_data/in_sel : producer side, in_sel picks the channel.
//   out_valid/out_ready/out_data     : per-channel consumer side; channel k
//                                      data sits at out_data[k*WIDTH +: WIDTH].
//   sel_err                          : one-cycle pulse when an out-of-range
//                                      word was accepted and dropped.
// Modports: slave = the demux, master = the surrounding producer/consumers.
interface stream_demux_if
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) ();

  localparam int unsigned SEL_W = sel_width(CHANNELS);

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;
  logic                      sel_err;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, sel_err
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, sel_err
  );

endinterface

// File: rtl/stream_demux_slot.sv
// One-entry output buffer for a single demux channel.
//   load      : write data_in this cycle (only asserted when can_load is high).
//   data_in   : word to store.
//   out_valid : buffer holds a word (the FULL/EMPTY state flop).
//   out_ready : consumer takes the word this cycle.
//   out_data  : stored word; holds its last value while empty.
//   can_load  : buffer is empty or being drained this cycle.
module stream_demux_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             can_load
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign can_load  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      // Load wins over drain so a simultaneous drain+refill stays FULL.
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1:N valid/ready demultiplexer with a one-entry buffer per channel.
//   clk, rst_n : clock and asynchronous active-low reset.
//   en         : global enable; while low no word is accepted, buffers drain.
//   bus        : stream_demux_if slave modport (producer, consumers, sel_err).
// Optional (macro STREAM_DEMUX_STATS_EN):
//   stat_clr   : synchronous clear of all transfer counters (beats increment).
//   stat_cnt   : per-channel saturating transfer counters, STAT_W bits each.
module stream_demux
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  stream_demux_if.slave              bus
`ifdef STREAM_DEMUX_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [CHANNELS*STAT_W-1:0] stat_cnt
`endif
);

  localparam int unsigned SEL_W = sel_width(CHANNELS);

  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] can_load;
  logic [CHANNELS-1:0] valid;
  logic                in_range;
  logic                sel_can_load;
  logic                accept;
  logic                sel_err_q;

  assign in_range = (32'(bus.in_sel) < CHANNELS);

  // Ready mux by loop compare so an out-of-range select never indexes past the
  // channel vector.
  always_comb begin
    sel_can_load = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (bus.in_sel == SEL_W'(k)) sel_can_load = can_load[k];
    end
  end

  assign bus.in_ready  = en && (!in_range || sel_can_load);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid;
  assign bus.sel_err   = sel_err_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
    assign load[k] = accept && (bus.in_sel == SEL_W'(k));

    stream_demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .data_in   (bus.in_data),
      .out_valid (valid[k]),
      .out_ready (bus.out_ready[k]),
      .out_data  (bus.out_data[k*WIDTH +: WIDTH]),
      .can_load  (can_load[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= accept && !in_range;
    end
  end

`ifdef STREAM_DEMUX_STATS_EN
  for (genvar k = 0; k < CHANNELS; k++) begin : g_stat
    logic [STAT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (stat_clr) begin
        cnt_q <= '0;
      end else if (valid[k] && bus.out_ready[k] && (cnt_q != STAT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign stat_cnt[k*STAT_W +: STAT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: a 4-channel instance for routing, stall,
// enable, throughput and reset, and a 5-channel instance for out-of-range
// selects. Counter checks are compiled in with STREAM_DEMUX_STATS_EN.
module tb_stream_demux;

  logic clk;
  logic rst_n;
  logic en;

  stream_demux_if #(.WIDTH(8), .CHANNELS(4)) b4 ();
  stream_demux_if #(.WIDTH(8), .CHANNELS(5)) b5 ();

`ifdef STREAM_DEMUX_STATS_EN
  logic        stat_clr;
  logic [63:0] stat_cnt4;
  logic [79:0] stat_cnt5;
`endif

  stream_demux #(
    .WIDTH    (8),
    .CHANNELS (4)
  ) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bus      (b4)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt4)
`endif
  );

  stream_demux #(
    .WIDTH    (8),
    .CHANNELS (5)
  ) u_dut5 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bus      (b5)
`ifdef STREAM_DEMUX_STATS_EN
    ,
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt5)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] data;
    logic [1:0] sel;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
    logic [7:0] exp_d;   // out_data of channel sel after the edge
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    rst_n        = 1'b0;
    en           = 1'b0;
    b4.in_valid  = 1'b0;
    b4.in_data   = '0;
    b4.in_sel    = '0;
    b4.out_ready = '0;
    b5.in_valid  = 1'b0;
    b5.in_data   = '0;
    b5.in_sel    = '0;
    b5.out_ready = '0;
`ifdef STREAM_DEMUX_STATS_EN
    stat_clr     = 1'b0;
`endif

    // Reset state.
    #2;
    chk("rst out_valid", 64'(b4.out_valid), 64'h0);
    chk("rst out_data", 64'(b4.out_data), 64'h0);
    chk("rst sel_err", 64'(b4.sel_err), 64'h0);
    chk("rst5 out_valid", 64'(b5.out_valid), 64'h0);
    #20 rst_n = 1'b1;
    tick();

    //           en vld data  sel   ordy     rdy ov       d
    vecs[0]  = '{1, 1, 8'hA5, 2'd2, 4'b1111, 1, 4'b0100, 8'hA5}; // route to ch2
    vecs[1]  = '{1, 0, 8'h00, 2'd2, 4'b1111, 1, 4'b0000, 8'hA5}; // drains, data held
    vecs[2]  = '{1, 1, 8'h11, 2'd1, 4'b0000, 1, 4'b0010, 8'h11}; // ch1 stalled
    vecs[3]  = '{1, 1, 8'h22, 2'd1, 4'b0000, 0, 4'b0010, 8'h11}; // blocked
    vecs[4]  = '{1, 1, 8'h33, 2'd3, 4'b0000, 1, 4'b1010, 8'h33}; // ch3 independent
    vecs[5]  = '{1, 0, 8'h00, 2'd1, 4'b0000, 0, 4'b1010, 8'h11}; // ch1 still 11
    vecs[6]  = '{0, 1, 8'h44, 2'd3, 4'b1010, 0, 4'b0000, 8'h33}; // en=0 drains
    vecs[7]  = '{1, 1, 8'h55, 2'd0, 4'b0000, 1, 4'b0001, 8'h55};
    vecs[8]  = '{1, 1, 8'h66, 2'd0, 4'b0001, 1, 4'b0001, 8'h66}; // drain + refill
    vecs[9]  = '{1, 1, 8'h77, 2'd0, 4'b0000, 0, 4'b0001, 8'h66};
    vecs[10] = '{0, 1, 8'h77, 2'd0, 4'b0001, 0, 4'b0000, 8'h66};

    for (int i = 0; i < NV; i++) begin
      en           = vecs[i].en;
      b4.in_valid  = vecs[i].vld;
      b4.in_data   = vecs[i].data;
      b4.in_sel    = vecs[i].sel;
      b4.out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("vec%0d in_ready", i), 64'(b4.in_ready), 64'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("vec%0d out_valid", i), 64'(b4.out_valid), 64'(vecs[i].exp_ov));
      chk($sformatf("vec%0d out_data", i),
          64'(b4.out_data[32'(vecs[i].sel)*8 +: 8]), 64'(vecs[i].exp_d));
      chk($sformatf("vec%0d sel_err", i), 64'(b4.sel_err), 64'h0);
    end

    // Throughput: 16 words to ch0, one per cycle, 1-cycle latency.
    en           = 1'b1;
    b4.out_ready = 4'b1111;
    b4.in_sel    = 2'd0;
    b4.in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b4.in_data = 8'(8'h80 + i);
      #1;
      chk($sformatf("thr%0d in_ready", i), 64'(b4.in_ready), 64'h1);
      tick();
      chk($sformatf("thr%0d out_valid", i), 64'(b4.out_valid), 64'h1);
      chk($sformatf("thr%0d out_data", i), 64'(b4.out_data[7:0]), 64'(8'h80 + i));
    end
    b4.in_valid = 1'b0;
    tick();
    chk("thr drained", 64'(b4.out_valid), 64'h0);

    // Out-of-range selects on the 5-channel instance.
    b5.out_ready = 5'b00000;
    b5.in_valid  = 1'b1;
    b5.in_sel    = 3'd4;
    b5.in_data   = 8'h44;
    #1;
    chk("n5 ch4 in_ready", 64'(b5.in_ready), 64'h1);
    tick();
    chk("n5 ch4 out_valid", 64'(b5.out_valid), 64'h10);
    chk("n5 ch4 out_data", 64'(b5.out_data[39:32]), 64'h44);
    b5.in_data = 8'h45;
    #1;
    chk("n5 ch4 full in_ready", 64'(b5.in_ready), 64'h0);
    en         = 1'b0;
    b5.in_sel  = 3'd6;
    b5.in_data = 8'h99;
    #1;
    chk("n5 en0 in_ready", 64'(b5.in_ready), 64'h0);
    en = 1'b1;
    for (int s = 5; s <= 6; s++) begin
      b5.in_valid = 1'b1;
      b5.in_sel   = 3'(s);
      #1;
      chk($sformatf("n5 sel%0d in_ready", s), 64'(b5.in_ready), 64'h1);
      tick();
      b5.in_valid = 1'b0;
      chk($sformatf("n5 sel%0d sel_err", s), 64'(b5.sel_err), 64'h1);
      chk($sformatf("n5 sel%0d out_valid", s), 64'(b5.out_valid), 64'h10);
      chk($sformatf("n5 sel%0d out_data4", s), 64'(b5.out_data[39:32]), 64'h44);
      tick();
      chk($sformatf("n5 sel%0d sel_err end", s), 64'(b5.sel_err), 64'h0);
    end

`ifdef STREAM_DEMUX_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat cleared", stat_cnt4, 64'h0);
    b4.out_ready = 4'b1111;
    b4.in_sel    = 2'd0;
    b4.in_valid  = 1'b1;
    repeat (3) tick();
    b4.in_valid = 1'b0;
    tick();
    chk("stat three", 64'(stat_cnt4[15:0]), 64'h3);
    b4.in_valid = 1'b1;
    repeat (70000) tick();
    b4.in_valid = 1'b0;
    tick();
    chk("stat saturate", 64'(stat_cnt4[15:0]), 64'hFFFF);
    chk("stat other ch", 64'(stat_cnt4[63:16]), 64'h0);
    b4.in_valid = 1'b1;
    tick();
    b4.in_valid = 1'b0;
    stat_clr    = 1'b1;   // ch0 full and ready: transfer coincides with clear
    tick();
    stat_clr = 1'b0;
    chk("stat clr wins", 64'(stat_cnt4[15:0]), 64'h0);
`endif

    // Reset mid-traffic: ch0 and ch2 full when reset asserts.
    b4.out_ready = 4'b0000;
    b4.in_valid  = 1'b1;
    b4.in_sel    = 2'd0;
    b4.in_data   = 8'hC0;
    tick();
    b4.in_sel  = 2'd2;
    b4.in_data = 8'hC2;
    tick();
    b4.in_valid = 1'b0;
    chk("pre-rst out_valid", 64'(b4.out_valid), 64'h5);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(b4.out_valid), 64'h0);
    chk("async rst out_data", 64'(b4.out_data), 64'h0);
    chk("async rst5 out_valid", 64'(b5.out_valid), 64'h0);
`ifdef STREAM_DEMUX_STATS_EN
    chk("async rst stat", stat_cnt4, 64'h0);
`endif
    #3;
    b4.out_ready = 4'b1111;
    rst_n        = 1'b1;
    tick();
    chk("post-rst out_valid", 64'(b4.out_valid), 64'h0);
    chk("post-rst out_data", 64'(b4.out_data), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
